// File: rtl/mic3_adc_responder_pkg.sv
// mic3_adc_responder_pkg: shared frame geometry, FSM encoding and synchroniser reset level
package mic3_adc_responder_pkg;
    localparam int   DATA_W_DEF     = 12;
    localparam int   LEAD_ZEROS_DEF = 4;
    localparam int   FRAME_W        = LEAD_ZEROS_DEF + DATA_W_DEF;
    localparam logic SYNC_RST       = 1'b1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/mic3_adc_responder_sync_edge_detect.sv
// mic3_adc_responder_sync_edge_detect: synchronise an async pin and flag its rising/falling edges
module mic3_adc_responder_sync_edge_detect
    import mic3_adc_responder_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{SYNC_RST}};
            prev_q <= SYNC_RST;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/mic3_adc_responder.sv
// mic3_adc_responder: Pmod MIC3 ADC slave model, sends {LEAD_ZEROS zeros, sample} MSB first on MISO
module mic3_adc_responder
    import mic3_adc_responder_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int LEAD_ZEROS  = LEAD_ZEROS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              sclk,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_load,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              stale
);
    localparam int FW = LEAD_ZEROS + DATA_W;
    localparam int CW = $clog2(FW);

    logic cs_rise, cs_fall, sclk_rise, sclk_fall;
    state_e            state_q, state_d;
    logic [FW-1:0]     shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic fresh_q, fresh_d, done_q, done_d, abort_q, abort_d, stale_q, stale_d;

    mic3_adc_responder_sync_edge_detect #(.STAGES(SYNC_STAGES)) u_cs (
        .clock(clock), .rst_n(rst_n), .d_i(cs_n), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    mic3_adc_responder_sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sclk (
        .clock(clock), .rst_n(rst_n), .d_i(sclk), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        hold_d  = sample_load ? sample_in : hold_q;
        fresh_d = fresh_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        stale_d = 1'b0;
        case (state_q)
            IDLE: if (cs_fall) begin
                state_d = SHIFT;
                shift_d = {{LEAD_ZEROS{1'b0}}, hold_q};
                cnt_d   = '0;
                fresh_d = 1'b0;
                stale_d = ~fresh_q;
            end
            SHIFT: if (cs_rise) begin
                state_d = IDLE;
                abort_d = 1'b1;
            end else if (sclk_fall) begin
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(FW - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // a load coinciding with capture still counts as fresh for the next frame
        if (sample_load) fresh_d = 1'b1;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            fresh_q <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            fresh_q <= fresh_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            stale_q <= stale_d;
        end
    end

    // sclk rising edges carry no action: the master samples on them
    logic unused_ok;
    assign unused_ok   = sclk_rise;
    assign busy        = state_q != IDLE;
    assign miso_oe     = busy;
    assign miso        = (state_q == SHIFT) & shift_q[FW-1];
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign stale       = stale_q;
endmodule

// File: tb/tb_mic3_adc_responder.sv
// tb_mic3_adc_responder: directed frame vectors plus collision and mid-frame reset sequences
module tb_mic3_adc_responder;
    logic        clock = 0;
    logic        rst_n = 0;
    logic        cs_n = 1, sclk = 1, sample_load = 0;
    logic [11:0] sample_in = '0;
    logic        miso, miso_oe, busy, frame_done, frame_abort, stale;
    int          tests = 0, fails = 0;
    int          n_done = 0, n_abort = 0, n_stale = 0;

    mic3_adc_responder dut (
        .clock(clock), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .miso(miso), .miso_oe(miso_oe),
        .sample_in(sample_in), .sample_load(sample_load), .busy(busy), .frame_done(frame_done),
        .frame_abort(frame_abort), .stale(stale)
    );

    always #5 clock = ~clock;
    always @(posedge clock) if (frame_done) n_done++;
    always @(posedge clock) if (frame_abort) n_abort++;
    always @(posedge clock) if (stale) n_stale++;

    typedef struct {
        logic        ld;
        logic [11:0] smp;
        int          nf;
        logic [15:0] word;
        int          done, abrt, stl;
    } vec_t;

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [11:0] v);
        sample_in = v;
        sample_load = 1;
        cyc(1);
        sample_load = 0;
        cyc(1);
    endtask

    task automatic frame(input int nf, output logic [15:0] w, output int nd, output int na, output int ns);
        int d0, a0, s0;
        d0 = n_done; a0 = n_abort; s0 = n_stale;
        w = '0;
        cs_n = 0;
        cyc(8);
        for (int k = 0; k < nf; k++) begin
            w = {w[14:0], miso};
            sclk = 0;
            cyc(8);
            sclk = 1;
            cyc(8);
        end
        chk("oe_during_frame", miso_oe, 1);
        cs_n = 1;
        cyc(2);
        chk("busy_2cyc_after_cs_rise", busy, 1);
        cyc(1);
        chk("busy_3cyc_after_cs_rise", busy, 0);
        chk("oe_after_frame", miso_oe, 0);
        cyc(3);
        nd = n_done - d0; na = n_abort - a0; ns = n_stale - s0;
    endtask

    vec_t vecs[6];
    logic [15:0] w;
    int nd, na, ns;

    initial begin
        vecs[0] = '{1, 12'hA5C, 16, 16'h0A5C, 1, 0, 0};
        vecs[1] = '{1, 12'h3FF, 7,  16'h0000, 0, 1, 0};
        vecs[2] = '{0, 12'h000, 16, 16'h03FF, 1, 0, 1};
        vecs[3] = '{1, 12'h123, 16, 16'h0123, 1, 0, 0};
        vecs[4] = '{0, 12'h000, 16, 16'h0123, 1, 0, 1};
        vecs[5] = '{1, 12'h111, 16, 16'h0111, 1, 0, 0};

        cyc(2);
        for (int k = 0; k < 6; k++) begin
            sclk = ~sclk; cs_n = k[0];
            cyc(2);
            chk("rst_miso", miso, 0);
            chk("rst_oe", miso_oe, 0);
            chk("rst_busy", busy, 0);
            chk("rst_pulses", {frame_done, frame_abort, stale}, 0);
        end
        cs_n = 1; sclk = 1;
        cyc(2);
        rst_n = 1;
        cyc(4);
        for (int k = 0; k < 4; k++) begin
            sclk = ~sclk;
            cyc(6);
        end
        chk("sclk_ignored_idle", {busy, n_done[7:0]}, 0);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].ld) load(vecs[i].smp);
            frame(vecs[i].nf, w, nd, na, ns);
            if (vecs[i].nf == 16) chk($sformatf("v%0d_word", i), w, vecs[i].word);
            chk($sformatf("v%0d_done", i), nd, vecs[i].done);
            chk($sformatf("v%0d_abort", i), na, vecs[i].abrt);
            chk($sformatf("v%0d_stale", i), ns, vecs[i].stl);
        end

        // collision: load 777 in the capture cycle (hold = 111, fresh = 1)
        load(12'h111);
        begin
            int s0;
            s0 = n_stale;
            cs_n = 0;
            cyc(2);
            sample_in = 12'h777;
            sample_load = 1;
            cyc(1);
            sample_load = 0;
            cyc(5);
            w = '0;
            for (int k = 0; k < 16; k++) begin
                w = {w[14:0], miso};
                sclk = 0; cyc(8); sclk = 1; cyc(8);
            end
            cs_n = 1;
            cyc(6);
            chk("coll_word", w, 16'h0111);
            chk("coll_stale", n_stale - s0, 0);
        end
        frame(16, w, nd, na, ns);
        chk("coll_next_word", w, 16'h0777);
        chk("coll_next_stale", ns, 0);

        // reset mid-frame after bit 9, hold = 777 so bit 5 is high at that point
        cs_n = 0;
        cyc(8);
        for (int k = 0; k < 10; k++) begin
            sclk = 0; cyc(8); sclk = 1; cyc(8);
        end
        chk("mid_oe_before_rst", miso_oe, 1);
        chk("mid_miso_before_rst", miso, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_miso", miso, 0);
        chk("mid_rst_oe", miso_oe, 0);
        chk("mid_rst_busy", busy, 0);
        cs_n = 1;
        cyc(4);
        rst_n = 1;
        cyc(4);
        frame(16, w, nd, na, ns);
        chk("post_rst_word", w, 16'h0000);
        chk("post_rst_stale", ns, 1);
        chk("post_rst_done", nd, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
